// File: rtl/integrated_mem_ctrl.sv
// integrated_mem_ctrl: program/data banks behind a fetch port and a load/store port, plus a handshaked MMIO window.
// Optional feature: define INTEGRATED_MEM_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses with err.
module integrated_mem_ctrl #(
  parameter int PROG_WORDS     = 4096,
  parameter int DATA_WORDS     = 4096,
  parameter int PROG_SEL_BIT   = 13,
  parameter int MMIO_SEL_BIT   = 14,
  parameter int MMIO_AW        = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic               if_ready,
  output logic               if_rvalid,
  output logic [31:0]        if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [2:0]         d_funct3,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  output logic               d_ready,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,
  output logic               mmio_req,
  output logic               mmio_we,
  output logic [MMIO_AW-1:0] mmio_addr,
  output logic [31:0]        mmio_wdata,
  output logic [3:0]         mmio_be,
  input  logic               mmio_ack,
  input  logic [31:0]        mmio_rdata,
  output logic               prog_busy,
  output logic               err
);
  localparam int PAW = $clog2(PROG_WORDS);
  localparam int DAW = $clog2(DATA_WORDS);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MMIO_WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t state_r, state_next_s;

  logic [31:0] prog_mem [PROG_WORDS];
  logic [31:0] data_mem [DATA_WORDS];

  logic [1:0]     off_s;
  logic [3:0]     be_s;
  logic [31:0]    wrep_s;
  logic           trap_s, is_mmio_s, is_data_s, is_prog_s;
  logic           d_acc_s, if_acc_s, mmio_start_s, tmo_hit_s;
  logic [PAW-1:0] d_pidx_s, f_idx_s;
  logic [DAW-1:0] d_didx_s;
  logic [31:0]    bank_word_s, load_fmt_s;
  logic [15:0]    tmo_cnt_r;
  logic [2:0]     resp_f3_r;
  logic [1:0]     resp_off_r;
  logic           unused_s;

  // Lane extraction plus sign/zero extension; any non-B/H code passes the word through
  function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  assign unused_s  = ^{if_addr, d_addr};
  assign is_mmio_s = d_addr[MMIO_SEL_BIT];
  assign is_data_s = !is_mmio_s && d_addr[PROG_SEL_BIT];
  assign is_prog_s = !is_mmio_s && !d_addr[PROG_SEL_BIT];
  assign d_pidx_s  = d_addr[PAW+1:2];
  assign d_didx_s  = d_addr[DAW+1:2];
  assign f_idx_s   = if_addr[PAW+1:2];

  assign d_ready      = !reset && (state_r == IDLE || state_r == RESP);
  assign d_acc_s      = d_req && d_ready;
  assign prog_busy    = d_acc_s && is_prog_s;
  assign if_ready     = !reset && !prog_busy;
  assign if_acc_s     = if_req && if_ready;
  assign mmio_start_s = d_acc_s && is_mmio_s && !trap_s;

`ifdef INTEGRATED_MEM_MISALIGN_TRAP_EN
  assign trap_s = (d_funct3[1:0] == 2'b00) ? 1'b0 :
                  (d_funct3[1:0] == 2'b01) ? d_addr[0] : (d_addr[1:0] != 2'b00);
`else
  assign trap_s = 1'b0;
`endif

  // Access size decode: lane offset (aligned down), byte enables and replicated store data
  always_comb begin
    off_s  = 2'b00;
    be_s   = 4'b1111;
    wrep_s = d_wdata;
    case (d_funct3[1:0])
      2'b00: begin
        off_s  = d_addr[1:0];
        be_s   = 4'b0001 << d_addr[1:0];
        wrep_s = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        off_s  = {d_addr[1], 1'b0};
        be_s   = d_addr[1] ? 4'b1100 : 4'b0011;
        wrep_s = {2{d_wdata[15:0]}};
      end
      default: begin
        off_s  = 2'b00;
        be_s   = 4'b1111;
        wrep_s = d_wdata;
      end
    endcase
  end

  assign bank_word_s = is_data_s ? data_mem[d_didx_s] : prog_mem[d_pidx_s];
  assign load_fmt_s  = fmt_load(bank_word_s, d_funct3, off_s);

  // Bank writes with per-lane enables; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (d_acc_s && d_we && !trap_s && !is_mmio_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          if (is_data_s) data_mem[d_didx_s][8*i +: 8] <= wrep_s[8*i +: 8];
          else           prog_mem[d_pidx_s][8*i +: 8] <= wrep_s[8*i +: 8];
        end
      end
    end
  end

  // Fetch response; a fetch blocked by a program-bank data access never reads a stale word
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
    end else begin
      if_rvalid <= if_acc_s;
      if_rdata  <= if_acc_s ? prog_mem[f_idx_s] : 32'd0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next state; ack takes priority over a timeout expiring in the same cycle
  always_comb begin
    state_next_s = state_r;
    tmo_hit_s    = 1'b0;
    case (state_r)
      IDLE, RESP: begin
        if (mmio_start_s) state_next_s = MMIO_WAIT;
        else              state_next_s = IDLE;
      end
      MMIO_WAIT: begin
        if (mmio_ack) begin
          state_next_s = RESP;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_next_s = RESP;
          tmo_hit_s    = 1'b1;
        end else begin
          state_next_s = MMIO_WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Data-port response and MMIO request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      d_rvalid   <= 1'b0;
      d_rdata    <= 32'd0;
      err        <= 1'b0;
      mmio_req   <= 1'b0;
      mmio_we    <= 1'b0;
      mmio_addr  <= '0;
      mmio_wdata <= 32'd0;
      mmio_be    <= 4'd0;
      tmo_cnt_r  <= 16'd0;
      resp_f3_r  <= 3'd0;
      resp_off_r <= 2'd0;
    end else begin
      d_rvalid <= 1'b0;
      d_rdata  <= 32'd0;
      err      <= 1'b0;
      if (state_r == MMIO_WAIT) begin
        if (mmio_ack) begin
          mmio_req <= 1'b0;
          d_rvalid <= 1'b1;
          d_rdata  <= mmio_we ? 32'd0 : fmt_load(mmio_rdata, resp_f3_r, resp_off_r);
        end else if (tmo_hit_s) begin
          mmio_req <= 1'b0;
          d_rvalid <= 1'b1;
          err      <= 1'b1;
        end else begin
          tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end
      end else if (d_acc_s) begin
        if (trap_s) begin
          d_rvalid <= 1'b1;
          err      <= 1'b1;
        end else if (is_mmio_s) begin
          mmio_req   <= 1'b1;
          mmio_we    <= d_we;
          mmio_addr  <= d_addr[MMIO_AW-1:0];
          mmio_wdata <= wrep_s;
          mmio_be    <= be_s;
          tmo_cnt_r  <= 16'd0;
          resp_f3_r  <= d_funct3;
          resp_off_r <= off_s;
        end else begin
          d_rvalid <= 1'b1;
          d_rdata  <= d_we ? 32'd0 : load_fmt_s;
        end
      end
    end
  end
endmodule

// File: doc/integrated_mem_ctrl.md
# integrated_mem_ctrl

Parametrised memory controller for the core. It owns a program bank and a data bank and exposes an instruction-fetch port and a data load/store port. A handshaked MMIO port gives the peripheral register window variable-latency access with a timeout. It adds RISC-V sub-word load/store formatting, fetch/data arbitration on the program bank, and an explicit valid/ready protocol.

## Interface
- PROG_WORDS, 4096: program bank depth in 32-bit words (power of two).
- DATA_WORDS, 4096: data bank depth in 32-bit words (power of two).
- PROG_SEL_BIT, 13: address bit selecting the data bank (1) or program bank (0).
- MMIO_SEL_BIT, 14: address bit selecting the MMIO window (overrides PROG_SEL_BIT).
- MMIO_AW, 14: MMIO address width (d_addr[MMIO_AW-1:0]).
- TIMEOUT_CYCLES, 255: maximum MMIO wait in cycles (≥1, fits 16 bits).

Ports:
- clk  in  1  the single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_ready  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, LSB-aligned.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid or store complete.
- d_rdata  out  32  formatted load data; 0 for stores.
- mmio_req  out  1  MMIO request, held until ack.
- mmio_we  out  1  MMIO write.
- mmio_addr  out  MMIO_AW  MMIO address.
- mmio_wdata  out  32  lane-shifted write data.
- mmio_be  out  4  byte enables.
- mmio_ack  in  1  MMIO completion.
- mmio_rdata  in  32  MMIO read word, sampled on ack.
- prog_busy  out  1  a data-port access occupies the program bank this cycle.
- err  out  1  one-cycle error pulse, coincident with d_rvalid.

## Operation
- Decode: d_addr[MMIO_SEL_BIT]=1 selects MMIO. Otherwise d_addr[PROG_SEL_BIT] selects data (1) or program (0). Bank word index is d_addr[log2(depth)+1:2], and upper bits wrap.
- FSM states:
  - IDLE: bank accesses complete here.
  - MMIO_WAIT: entered on an accepted MMIO request.
  - RESP: one cycle; d_rvalid is driven, then the FSM returns to IDLE.
- Data port: d_ready=1 in IDLE and in RESP, else 0. A request is accepted when d_req & d_ready.
- Arbitration: if an accepted data access targets the program bank, data wins. That cycle if_ready=0 and prog_busy=1. Otherwise if_ready=1.
- Stores: mem byte enables come from funct3 and d_addr[1:0]:
  - B: 1 lane.
  - H: lanes {0,1} or {2,3}.
  - W: all 4 lanes.
  - Data is replicated to the selected lanes.
- Loads: the lane is selected by d_addr[1:0]. B/H are sign-extended, BU/HU zero-extended, W is passed through.
- MMIO:
  - mmio_* are registered from the request.
  - mmio_req stays high until the first cycle with mmio_ack=1.
  - The timeout counter is cleared on entry.
  - If the count reaches TIMEOUT_CYCLES without ack: mmio_req drops, RESP is entered with d_rdata=0 and err=1.
- Illegal funct3 (011, 110, 111): the access completes as W.
- Reset:
  - All outputs are 0 and the FSM is in IDLE. Bank contents are not cleared.
  - Reset during MMIO_WAIT drops mmio_req on that edge and discards the transaction; no d_rvalid follows.

## Timing
- Bank load/store: accepted in cycle N; d_rvalid and d_rdata in cycle N+1. Back-to-back accesses run at 1 per cycle.
- Fetch: accepted in N; if_rvalid and if_rdata in N+1. if_rvalid=0 in the cycle after a blocked fetch.
- A store followed by a load to the same word in the next cycle returns the new data (write-first).
- MMIO:
  - Accepted in N; mmio_req=1 from N+1.
  - Ack in cycle M; d_rvalid in M+1; the next request is accepted in M+1.
  - Ack in the same cycle the timeout expires: ack wins, err=0.
- If fetch and data both target the same program word in one cycle, the fetch is retried, so no stale data is ever returned.

## Configuration
- INTEGRATED_MEM_MISALIGN_TRAP_EN defined:
  - H/HU with d_addr[0]=1, or W with d_addr[1:0]≠0, is not performed.
  - The bank is not written and no MMIO request is made.
  - d_rvalid comes next cycle with d_rdata=0 and err=1.
- Undefined: the low address bits are aligned down to the access size (H uses addr[1], W ignores [1:0]). err is raised only on MMIO timeout.

## Test plan
- SW 0xDEADBEEF to 0x2000, then LB/LBU/LH/LHU at 0x2003/0x2003/0x2002/0x2002 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, each 1 cycle after accept.
- Continuous fetch of 0x0000.. while SW 0x12345678 goes to 0x0010 -> if_ready=0 and prog_busy=1 in that cycle only; a later fetch of 0x0010 returns 0x12345678.
- LW at 0x4004 with mmio_ack after 3 cycles, mmio_rdata=0xA5A5A5A5 -> mmio_addr=0x0004, mmio_be=4'hF, d_rvalid with 0xA5A5A5A5, err=0.
- MMIO read with ack never asserted, TIMEOUT_CYCLES=8 -> mmio_req drops after 8 cycles, d_rvalid with d_rdata=0, err=1.
- SH to 0x2001 -> with the macro: err=1 and the word is unchanged; without it: lanes {0,1} are written.
- Reset asserted during MMIO_WAIT -> mmio_req=0 next cycle, no d_rvalid, d_ready=1 after reset.
